// File: rtl/four_two_prio_enc_pkg.sv
// rtl/four_two_prio_enc_pkg.sv - shared constants and width helper for the registered priority encoder
//
// Contents:
//   IN_W_DEFAULT  default number of request lines (4)
//   IN_W_MIN/MAX  legal request-width range (2..32)
//   calc_out_w()  index width derived from the request width
//   Y_RST         reset value of the registered index
//   VALID_RST     reset value of the registered valid flag
package four_two_prio_enc_pkg;

    localparam int IN_W_DEFAULT = 4;
    localparam int IN_W_MIN     = 2;
    localparam int IN_W_MAX     = 32;

    localparam int   Y_RST     = 0;
    localparam logic VALID_RST = 1'b0;

    // Index width is fully determined by the request width; it is never
    // set independently so that y can always represent IN_W-1 untruncated.
    function automatic int calc_out_w(input int in_w);
        return $clog2(in_w);
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// rtl/prio_enc_comb.sv - combinational highest-index-wins priority encoder
//
// Parameters:
//   IN_W   number of request lines
//   OUT_W  index width (derived from IN_W)
// Ports:
//   req  in   IN_W   request vector, bit k = request k
//   idx  out  OUT_W  index of the highest set bit of req, 0 when none set
//   any  out  1      high when at least one bit of req is set
module prio_enc_comb
    import four_two_prio_enc_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEFAULT,
    localparam int OUT_W = calc_out_w(IN_W)
) (
    input  logic [IN_W-1:0]  req,
    output logic [OUT_W-1:0] idx,
    output logic             any
);

    // Scan from the top down; the first set bit found wins and locks out
    // every lower bit, which is exactly the "highest index wins" rule.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = IN_W - 1; k >= 0; k--) begin
            if (req[k] && !any) begin
                idx = OUT_W'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_two_prio_enc.sv
// rtl/four_two_prio_enc.sv - registered priority encoder with capture enable and valid flag
//
// Parameters:
//   IN_W   number of request lines, 2..32 (default 4)
//   OUT_W  index width, derived as $clog2(IN_W)
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   en     in   1      capture enable; outputs hold while low
//   i      in   IN_W   request vector
//   y      out  OUT_W  registered index of the highest set bit of i
//   valid  out  1      registered flag, high when the captured i was nonzero
module four_two_prio_enc
    import four_two_prio_enc_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEFAULT,
    localparam int OUT_W = calc_out_w(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] y,
    output logic             valid
);

    if (IN_W < IN_W_MIN || IN_W > IN_W_MAX) begin : g_bad_in_w
        $error("four_two_prio_enc: IN_W=%0d outside legal range %0d..%0d",
               IN_W, IN_W_MIN, IN_W_MAX);
    end

    logic [OUT_W-1:0] enc_idx;
    logic             enc_any;

    prio_enc_comb #(
        .IN_W (IN_W)
    ) u_enc (
        .req (i),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Single register stage: outputs depend only on flops, so there is no
    // combinational path from i. Reset clears immediately and drops whatever
    // sample was about to be captured; nothing is replayed afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= OUT_W'(Y_RST);
            valid <= VALID_RST;
        end else if (en) begin
            y     <= enc_idx;
            valid <= enc_any;
        end
    end

endmodule

// File: tb/tb_four_two_prio_enc.sv
// tb/tb_four_two_prio_enc.sv - self-checking bench for four_two_prio_enc at IN_W=4 and IN_W=8
module tb_four_two_prio_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] i4;
    logic [7:0] i8;
    logic [1:0] y4;
    logic       v4;
    logic [2:0] y8;
    logic       v8;

    int passed = 0;
    int total  = 0;

    int exp4_y = 0;
    int exp4_v = 0;
    int exp8_y = 0;
    int exp8_v = 0;

    always #5 clk = ~clk;

    four_two_prio_enc d4 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .i     (i4),
        .y     (y4),
        .valid (v4)
    );

    four_two_prio_enc #(.IN_W(8)) d8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .i     (i8),
        .y     (y8),
        .valid (v8)
    );

    // Reference: position of the highest set bit is floor(log2(v)).
    function automatic int ref_y(input int unsigned v);
        int n = 0;
        if (v == 0) return 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_y4"}, int'(y4), exp4_y);
        check({tag, "_v4"}, int'(v4), exp4_v);
        check({tag, "_y8"}, int'(y8), exp8_y);
        check({tag, "_v8"}, int'(v8), exp8_v);
    endtask

    // Called at a falling edge: drive inputs, confirm outputs have not moved
    // before the rising edge, then confirm the captured result after it.
    task automatic cycle(input logic [3:0] a, input logic [7:0] b, input logic e);
        i4 = a;
        i8 = b;
        en = e;
        #1;
        check_all("pre_edge");
        @(posedge clk);
        if (e) begin
            exp4_y = ref_y(int'(a));
            exp4_v = (a != 0) ? 1 : 0;
            exp8_y = ref_y(int'(b));
            exp8_v = (b != 0) ? 1 : 0;
        end
        @(negedge clk);
        check_all("post_edge");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        i4    = 4'hF;
        i8    = 8'hFF;
        #1;
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'hF, 8'hFF, 1'b1);
        check("first_capture_y", int'(y4), 3);

        for (int v = 0; v < 16; v++) begin
            cycle(4'(v), 8'(v * 16 + v), 1'b1);
        end

        cycle(4'b0100, 8'h10, 1'b1);
        check("hold_capture_y", int'(y4), 2);
        for (int n = 0; n < 3; n++) begin
            cycle(4'b1000, 8'h80, 1'b0);
            check("hold_y", int'(y4), 2);
            check("hold_v", int'(v4), 1);
        end
        cycle(4'b1000, 8'h80, 1'b1);
        check("hold_release_y", int'(y4), 3);

        for (int n = 0; n < 4; n++) begin
            cycle(4'b0001, 8'h01, 1'b1);
            check("idx0_v1", int'(v4), 1);
            cycle(4'b0000, 8'h00, 1'b1);
            check("idx0_v0", int'(v4), 0);
        end

        cycle(4'hF, 8'hFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp4_y = 0; exp4_v = 0; exp8_y = 0; exp8_v = 0;
        check_all("async_reset");
        i4 = 4'b0110;
        i8 = 8'b0100_0001;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        exp4_y = 2; exp4_v = 1; exp8_y = 6; exp8_v = 1;
        @(negedge clk);
        check_all("after_reset");

        cycle(4'h0, 8'b0100_0001, 1'b1);
        check("w8_0x41_y", int'(y8), 6);
        cycle(4'h0, 8'h80, 1'b1);
        check("w8_0x80_y", int'(y8), 7);

        for (int n = 0; n < 60; n++) begin
            cycle(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)),
                  ($urandom_range(3, 0) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/four_two_prio_enc.md
Name: four_two_prio_enc

Overview:
- Registered priority encoder: maps a one-hot-or-more request vector to the binary index of its highest-set bit.
- Default configuration is 4 request lines to a 2-bit index. This is the drop-in clocked version of the combinational 4:2 encoder used in datapath arbitration/select logic.
- Adds a valid flag so an all-zero input is distinguishable from index 0.

Parameters:
- IN_W, 4, number of request inputs; legal range 2..32.
- OUT_W, $clog2(IN_W) (2 at default), index width; derived, not to be overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- en  input  1  capture enable; when low, registered outputs hold.
- i  input  IN_W  request vector; bit k = request k.
- y  output  OUT_W  index of the highest-numbered set bit of i, registered.
- valid  output  1  high when the captured i had at least one bit set, registered.

Behaviour:
- Priority rule: the highest index wins.
  - y = max{k : i[k]=1}.
  - Lower bits are ignored whenever a higher bit is set.
- All-zero input: y = 0 and valid = 0.
- Any nonzero input: valid = 1.
- Combinational encode is followed by one register stage.
  - Latency is exactly 1 clock: i sampled at edge n appears on y/valid after edge n.
  - No combinational path from i to outputs.
- en = 0: y and valid keep their previous values; i is ignored that cycle.
- Reset:
  - While rst_n = 0, y = 0 and valid = 0, immediately and independent of clk.
  - The first capture occurs on the first rising edge with rst_n = 1 and en = 1.
- Reset mid-operation: outputs clear asynchronously; the in-flight sample is discarded and there is no replay.
- Truth table at default width (i -> y, valid):
  - 0000 -> 0, 0
  - 0001 -> 0, 1
  - 001x -> 1, 1
  - 01xx -> 2, 1
  - 1xxx -> 3, 1
- X/Z on i: not supported; behaviour is don't-care but must not corrupt state after the next valid capture.
- Width rules:
  - y is zero-extended index, never truncated.
  - Elaboration must fail (assertion/$error) if IN_W < 2 or IN_W > 32.
- No handshake beyond en; there is no backpressure.

Decomposition:
- Shared package four_two_prio_enc_pkg holds:
  - default IN_W constant;
  - a function computing OUT_W;
  - the reset value constants (Y_RST = 0, VALID_RST = 0).
- One natural sub-module: prio_enc_comb.
  - Purely combinational, parameterised by IN_W.
  - Outputs idx and any.
  - Implemented as a descending-priority loop.
- four_two_prio_enc wraps prio_enc_comb with the output register, en gating and async reset.

Test Plan:
- Reset: drive rst_n = 0 with i = 1111 -> y = 0 and valid = 0 immediately, with no clock edge needed. Release rst_n, apply one edge with en = 1 -> y = 3, valid = 1.
- Exhaustive sweep at default width: i = 0000..1111, one value per cycle, en = 1 -> each result one cycle later matches the truth table. In particular:
  - 0000 -> 0/0
  - 0011 -> 1/1
  - 0101 -> 2/1
  - 1001 -> 3/1
  - 1111 -> 3/1
- Hold: capture i = 0100 (y = 2), then drive en = 0 while i = 1000 for 3 cycles -> y stays 2, valid stays 1. Raise en -> y = 3 next cycle.
- Zero vs index 0: alternate i = 0001 and i = 0000 -> y = 0 in both cases; valid toggles 1/0.
- Async reset mid-stream: during a sweep, pulse rst_n low between clock edges -> outputs drop to 0/0 within the same cycle. After release, the next capture is correct.
- Parameter check: IN_W = 8, i = 8'b0100_0001 -> y = 6 (3-bit), valid = 1; i = 8'h80 -> y = 7.
